// File: rtl/lane_lamp_driver_pkg.sv
// Shared traffic definitions: lane codes, lamp encodings, controller state enum and lamp decode helpers.
// The FLASH state exists only when FLASH_ON_FAULT_EN is defined.
package lane_lamp_driver_pkg;

  localparam logic [7:0] LANE_NS = 8'b00110011;
  localparam logic [7:0] LANE_EW = 8'b11001100;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    IDLE   = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    ALLRED = 3'd4
`ifdef FLASH_ON_FAULT_EN
    ,
    FLASH  = 3'd5
`endif
  } laneState_e;

  function automatic logic isLegal(input logic [7:0] code);
    return (code == LANE_NS) || (code == LANE_EW);
  endfunction

  // One direction's lamp; dirOn means the direction belongs to the active lane.
  function automatic logic [2:0] lampFor(input laneState_e st, input logic dirOn, input logic dark);
    if (dark) return LAMP_OFF;
    if (dirOn && (st == GREEN)) return LAMP_GRN;
    if (dirOn && (st == YELLOW)) return LAMP_YEL;
    return LAMP_RED;
  endfunction

endpackage

// File: rtl/lane_lamp_driver_phase_timer.sv
// phase_timer: loadable down-counter that stops at zero; done marks the last cycle of an interval.
// Shared with the day-time sequencer.
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic             done,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WIDTH'(1));
  assign zero = (count == '0);

endmodule

// File: rtl/lane_lamp_driver.sv
// lane_lamp_driver: accepts lane requests and sequences the N/E/S/W lamps with yellow, all-red and min-green timing.
// Optional FLASH_ON_FAULT_EN: an illegal lane code makes every lamp flash red/dark until reset.
module lane_lamp_driver
  import lane_lamp_driver_pkg::*;
#(
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int MIN_GREEN     = 4,
  parameter int FLASH_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lane_req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [2:0] lamp_n,
  output logic [2:0] lamp_e,
  output logic [2:0] lamp_s,
  output logic [2:0] lamp_w,
  output logic [7:0] active_lane,
  output logic       fault,
  output laneState_e dbgState
);

  localparam int MAX_YR  = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
  localparam int MAX_GF  = (MIN_GREEN > FLASH_CYCLES) ? MIN_GREEN : FLASH_CYCLES;
  localparam int MAX_ALL = (MAX_YR > MAX_GF) ? MAX_YR : MAX_GF;
  localparam int TW      = $clog2(MAX_ALL) + 1;

  localparam logic [TW-1:0] T_YEL    = TW'(YELLOW_CYCLES);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_CYCLES);
  localparam logic [TW-1:0] T_CLEAR1 = TW'(ALLRED_CYCLES - 1);
  localparam logic [TW-1:0] T_GREEN  = TW'(MIN_GREEN);
`ifdef FLASH_ON_FAULT_EN
  localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_CYCLES);
`endif

  laneState_e    state, stateNext;
  logic [7:0]    activeLane, activeNext;
  logic [7:0]    pendingLane, pendingNext;
  logic          faultReg, faultNext;
  logic          timerLoad, timerDone, timerZero;
  logic [TW-1:0] timerLoadVal;
  logic          accept, legalReq, flashDark;
`ifdef FLASH_ON_FAULT_EN
  logic          flashPhase, flashNext;
`endif

  phase_timer #(.WIDTH(TW)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .done    (timerDone),
    .zero    (timerZero)
  );

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
  // the producer holds lane_req stable until then, and req_ready never depends on req_valid.
  assign req_ready = (state == IDLE) || ((state == GREEN) && timerZero);
  assign accept    = req_valid && req_ready;
  assign legalReq  = isLegal(lane_req);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CLEAR;
      activeLane  <= '0;
      pendingLane <= '0;
      faultReg    <= 1'b0;
`ifdef FLASH_ON_FAULT_EN
      flashPhase  <= 1'b0;
`endif
    end else begin
      state       <= stateNext;
      activeLane  <= activeNext;
      pendingLane <= pendingNext;
      faultReg    <= faultNext;
`ifdef FLASH_ON_FAULT_EN
      flashPhase  <= flashNext;
`endif
    end
  end

  always_comb begin
    stateNext    = state;
    activeNext   = activeLane;
    pendingNext  = pendingLane;
    faultNext    = faultReg;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
`ifdef FLASH_ON_FAULT_EN
    flashNext    = flashPhase;
`endif
    case (state)
      // Reset leaves the timer at zero, so the first CLEAR cycle stands in for the load.
      CLEAR: begin
        if (timerDone || (timerZero && (ALLRED_CYCLES == 1))) begin
          stateNext = IDLE;
        end else if (timerZero) begin
          timerLoad    = 1'b1;
          timerLoadVal = T_CLEAR1;
        end
      end
      IDLE: begin
        if (accept && legalReq) begin
          stateNext    = GREEN;
          activeNext   = lane_req;
          timerLoad    = 1'b1;
          timerLoadVal = T_GREEN;
        end
      end
      GREEN: begin
        if (accept && legalReq && (lane_req != activeLane)) begin
          stateNext    = YELLOW;
          pendingNext  = lane_req;
          timerLoad    = 1'b1;
          timerLoadVal = T_YEL;
        end
      end
      YELLOW: begin
        if (timerDone) begin
          stateNext    = ALLRED;
          activeNext   = '0;
          timerLoad    = 1'b1;
          timerLoadVal = T_ALLRED;
        end
      end
      ALLRED: begin
        if (timerDone) begin
          stateNext    = GREEN;
          activeNext   = pendingLane;
          timerLoad    = 1'b1;
          timerLoadVal = T_GREEN;
        end
      end
`ifdef FLASH_ON_FAULT_EN
      FLASH: begin
        if (timerDone) begin
          flashNext    = ~flashPhase;
          timerLoad    = 1'b1;
          timerLoadVal = T_FLASH;
        end
      end
`endif
      default: stateNext = CLEAR;
    endcase

    // Accepts only happen in IDLE/GREEN, so this covers every ready state.
    if (accept && !legalReq) begin
      faultNext = 1'b1;
`ifdef FLASH_ON_FAULT_EN
      stateNext    = FLASH;
      activeNext   = '0;
      flashNext    = 1'b0;
      timerLoad    = 1'b1;
      timerLoadVal = T_FLASH;
`endif
    end
  end

`ifdef FLASH_ON_FAULT_EN
  assign flashDark = (state == FLASH) && flashPhase;
`else
  assign flashDark = 1'b0;
`endif

  assign lamp_n      = lampFor(state, |activeLane[1:0], flashDark);
  assign lamp_e      = lampFor(state, |activeLane[3:2], flashDark);
  assign lamp_s      = lampFor(state, |activeLane[5:4], flashDark);
  assign lamp_w      = lampFor(state, |activeLane[7:6], flashDark);
  assign active_lane = activeLane;
  assign fault       = faultReg;
  assign dbgState    = state;

endmodule

// File: tb/tb_lane_lamp_driver.sv
// Self-checking bench for lane_lamp_driver: vector table plus hand-written corner sequences, scoreboard queue.
module tb_lane_lamp_driver;
  import lane_lamp_driver_pkg::*;

  localparam int W = 25; // {state[3], lamps n,e,s,w [12], active[8], ready, fault}

  localparam logic [11:0] L_RED = {3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [11:0] L_NSG = {3'b001, 3'b100, 3'b001, 3'b100};
  localparam logic [11:0] L_NSY = {3'b010, 3'b100, 3'b010, 3'b100};
  localparam logic [11:0] L_EWG = {3'b100, 3'b001, 3'b100, 3'b001};
  localparam logic [11:0] L_EWY = {3'b100, 3'b010, 3'b100, 3'b010};
  localparam logic [11:0] L_OFF = 12'h000;
  localparam logic [7:0]  NS    = 8'b00110011;
  localparam logic [7:0]  EW    = 8'b11001100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] lane_req = 8'h00;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] lamp_n, lamp_e, lamp_s, lamp_w;
  logic [7:0] active_lane;
  logic       fault;
  laneState_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst_v;
    logic         valid;
    logic [7:0]   req;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  lane_lamp_driver dut (
    .clk         (clk),
    .rst         (rst),
    .lane_req    (lane_req),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .lamp_n      (lamp_n),
    .lamp_e      (lamp_e),
    .lamp_s      (lamp_s),
    .lamp_w      (lamp_w),
    .active_lane (active_lane),
    .fault       (fault),
    .dbgState    (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input laneState_e s, input logic [11:0] l,
                                      input logic [7:0] a, input logic rdy, input logic f);
    return {3'(s), l, a, rdy, f};
  endfunction

  function automatic void add(input logic r, input logic v, input logic [7:0] q, input logic [W-1:0] e);
    vec_t t;
    t.rst_v = r;
    t.valid = v;
    t.req   = q;
    t.exp   = e;
    vecs.push_back(t);
  endfunction

  // scoreboard: pop one expectation per clock and compare, plus per-cycle lamp safety
  task automatic check_out(input string name);
    logic [W-1:0] e, got;
    logic [11:0]  el;
    logic         ns_g, ew_g;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e   = exp_q.pop_front();
    got = {3'(dbg_state), lamp_n, lamp_e, lamp_s, lamp_w, active_lane, req_ready, fault};
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d lamps=%03b_%03b_%03b_%03b active=%08b ready=%b fault=%b, want state=%0d lamps=%03b_%03b_%03b_%03b active=%08b ready=%b fault=%b",
               name, got[24:22], got[21:19], got[18:16], got[15:13], got[12:10], got[9:2], got[1], got[0],
               e[24:22], e[21:19], e[18:16], e[15:13], e[12:10], e[9:2], e[1], e[0]);
    end
    checks++;
    ns_g = (lamp_n == 3'b001) || (lamp_s == 3'b001);
    ew_g = (lamp_e == 3'b001) || (lamp_w == 3'b001);
    if (ns_g && ew_g) begin
      errors++;
      $display("FAIL %s conflict: got n=%03b e=%03b s=%03b w=%03b, want no crossing greens", name, lamp_n, lamp_e, lamp_s, lamp_w);
    end
    el = e[21:10];
    if (el != L_OFF) begin
      checks++;
      if (!($onehot(lamp_n) && $onehot(lamp_e) && $onehot(lamp_s) && $onehot(lamp_w))) begin
        errors++;
        $display("FAIL %s onehot: got n=%03b e=%03b s=%03b w=%03b, want one bit each", name, lamp_n, lamp_e, lamp_s, lamp_w);
      end
    end
  endtask

  // driver: apply inputs away from the edge, push expectation, sample #1 after the edge
  task automatic step(input logic r, input logic v, input logic [7:0] q, input logic [W-1:0] e, input string name);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    lane_req  = q;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic reset_to_idle(input logic keep_fault_expect);
    step(1'b0, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0), "rst");
    step(1'b1, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0), "clear1");
    step(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b0 & keep_fault_expect), "clear_done");
  endtask

  initial begin
    int n_idle;

    // ---- vector table ----
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b0));
    add(1'b1, 1'b1, NS, mk(GREEN, L_NSG, NS, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 8'h00, mk(GREEN, L_NSG, NS, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(GREEN, L_NSG, NS, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) add(1'b1, 1'b1, NS, mk(GREEN, L_NSG, NS, 1'b1, 1'b0));
    add(1'b1, 1'b1, EW, mk(YELLOW, L_NSY, NS, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, mk(YELLOW, L_NSY, NS, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, mk(ALLRED, L_RED, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 8'h00, mk(GREEN, L_EWG, EW, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(GREEN, L_EWG, EW, 1'b1, 1'b0));
    add(1'b0, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0));
    add(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b0));
`ifdef FLASH_ON_FAULT_EN
    add(1'b1, 1'b1, 8'b10101010, mk(FLASH, L_RED, 8'h00, 1'b0, 1'b1));
    add(1'b1, 1'b0, 8'h00, mk(FLASH, L_RED, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, mk(FLASH, L_OFF, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 2; i++) add(1'b1, 1'b1, NS, mk(FLASH, L_RED, 8'h00, 1'b0, 1'b1));
`else
    add(1'b1, 1'b1, 8'b10101010, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b1));
    add(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b1));
    add(1'b1, 1'b1, NS, mk(GREEN, L_NSG, NS, 1'b0, 1'b1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_v, vecs[i].valid, vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // ---- hand sequence: request held while not ready, then reset in the middle of YELLOW ----
    reset_to_idle(1'b0);
    n_idle = $urandom_range(0, 3);
    for (int i = 0; i < n_idle; i++) step(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b0), "idle_gap");
    step(1'b1, 1'b1, EW, mk(GREEN, L_EWG, EW, 1'b0, 1'b0), "ew_accept");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, NS, mk(GREEN, L_EWG, EW, 1'b0, 1'b0), "held_not_ready");
    step(1'b1, 1'b1, NS, mk(GREEN, L_EWG, EW, 1'b1, 1'b0), "held_ready_rise");
    step(1'b1, 1'b1, NS, mk(YELLOW, L_EWY, EW, 1'b0, 1'b0), "held_accept");
    step(1'b1, 1'b0, 8'h00, mk(YELLOW, L_EWY, EW, 1'b0, 1'b0), "yellow2");
    step(1'b0, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0), "rst_in_yellow");
    step(1'b1, 1'b0, 8'h00, mk(CLEAR, L_RED, 8'h00, 1'b0, 1'b0), "clear_restart");
    step(1'b1, 1'b0, 8'h00, mk(IDLE, L_RED, 8'h00, 1'b1, 1'b0), "clear_restart_done");

    // ---- hand sequence: illegal code accepted while green ----
    step(1'b1, 1'b1, NS, mk(GREEN, L_NSG, NS, 1'b0, 1'b0), "ns_accept2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, mk(GREEN, L_NSG, NS, 1'b0, 1'b0), "min_green2");
    step(1'b1, 1'b0, 8'h00, mk(GREEN, L_NSG, NS, 1'b1, 1'b0), "min_green2_done");
`ifdef FLASH_ON_FAULT_EN
    step(1'b1, 1'b1, 8'hFF, mk(FLASH, L_RED, 8'h00, 1'b0, 1'b1), "illegal_in_green");
`else
    step(1'b1, 1'b1, 8'hFF, mk(GREEN, L_NSG, NS, 1'b1, 1'b1), "illegal_in_green");
    step(1'b1, 1'b1, EW, mk(YELLOW, L_NSY, NS, 1'b0, 1'b1), "change_after_fault");
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_lamp_driver.md
# lane_lamp_driver

Consumer end of the lane-code interface: accepts 8-bit lane requests (WWSSEENN; 00110011 = N+S, 11001100 = E+W) from the day/night sequencers and drives the per-direction red/yellow/green lamps. Inserts yellow and all-red clearance intervals, enforces a minimum green time and back-pressures the producer with a valid/ready handshake. Sits between the lane-pattern generators and the lamp output pins.

## Interface
- YELLOW_CYCLES, 3: yellow duration in clocks (≥1)
- ALLRED_CYCLES, 2: all-red clearance in clocks (≥1)
- MIN_GREEN, 4: clocks a green holds before a new request is accepted (≥1)
- FLASH_CYCLES, 2: half-period of fault flash (only with FLASH_ON_FAULT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- lane_req  in  8  requested lane code, WWSSEENN
- req_valid  in  1  lane_req valid; held stable until accepted
- req_ready  out  1  block can accept a request this cycle
- lamp_n, lamp_e, lamp_s, lamp_w  out  3 each  {red,yellow,green}, one-hot
- active_lane  out  8  lane code currently green or yellow; 8'h00 when all red
- fault  out  1  sticky: an illegal lane code was accepted

## Operation
- Accept = req_valid && req_ready at a rising edge. Legal codes are LANE_NS and LANE_EW only; every other value is illegal.
- States: CLEAR, IDLE, GREEN, YELLOW, ALLRED (plus FLASH under the macro).
- CLEAR: all lamps red, req_ready=0. Entered on reset. Leaves for IDLE after ALLRED_CYCLES.
- IDLE: all lamps red, req_ready=1. A legal accept moves to GREEN with active_lane=lane_req.
- GREEN: the active lane's two directions are green, the others red. req_ready=1 only once MIN_GREEN cycles have elapsed in GREEN.
  - Accepting the same code is a no-op: the lamps stay green and the min-green timer is not restarted.
  - Accepting the other legal code stores it as pending and moves to YELLOW.
- YELLOW: the active directions are yellow, the others red, req_ready=0. Lasts YELLOW_CYCLES, then moves to ALLRED with active_lane=0.
- ALLRED: all lamps red, req_ready=0. Lasts ALLRED_CYCLES, then moves to GREEN with active_lane set to the pending code.
- Illegal accept, in any ready state: the request is dropped, fault is set, and the state is otherwise unchanged.
- Reset is dominant. rst=0 at any edge, mid-interval included, forces CLEAR, zeroes the timer and the pending register, and clears fault.
- The timer is one down-counter, width $clog2(max of parameters)+1, loaded on state entry. The state advances at the edge where the counter reaches 1, so every interval is exact.

## Timing
- All outputs come from registers or are decoded from the registered state alone; there is no combinational input-to-output path.
- Reset values: lamps all 3'b100, active_lane=8'h00, req_ready=0, fault=0.
- After reset deassert, req_ready rises after exactly ALLRED_CYCLES clocks.
- For an accept at edge k in IDLE, the new lamps are visible after edge k, i.e. a 1-cycle latency.
- Lane change accepted at edge k: yellow for edges k..k+Y-1, all-red for the following R cycles, new green from edge k+Y+R. req_ready stays 0 until MIN_GREEN more cycles have elapsed.
- Exactly one lamp bit is high per direction in every cycle.

## Configuration
- FLASH_ON_FAULT_EN defined: an illegal accept enters FLASH. In FLASH all lamps toggle between red and dark (3'b000) every FLASH_CYCLES, req_ready=0, and active_lane=0. Only reset exits FLASH.
- FLASH_ON_FAULT_EN undefined: an illegal code only sets fault, and no FLASH state is synthesised.

## Structure
- A shared traffic package holds:
  - LANE_NS=8'b00110011, LANE_EW=8'b11001100
  - LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000
  - the state enum
- Sub-module phase_timer: loadable down-counter with a load value and a done flag, parameterised by width. It is reused by the day-time sequencer.

## Test plan
- Reset held 3 cycles, then released: all lamps red and ready=0 for 2 cycles, ready=1 on the 3rd, fault=0.
- From IDLE, request 00110011: next cycle lamp_n=lamp_s=001, lamp_e=lamp_w=100, active_lane=00110011, ready=0 for 4 cycles then 1.
- In NS green, request 11001100: N/S yellow for 3 cycles, all red for 2, then E/W green. No cycle shows conflicting greens.
- Request 10101010 in IDLE: fault=1 next cycle and lamps unchanged. With FLASH_ON_FAULT_EN, lamps alternate 100/000 every 2 cycles.
- rst=0 asserted during YELLOW: next cycle all red, active_lane=0, fault=0, and the CLEAR interval restarts.
- NS green, req_valid held with 00110011 for 10 cycles: lamps never leave green and ready stays 1 after min-green.
